// File: rtl/sticky_cpu_core.sv
// Sticky CPU core: 16-bit register machine fed 32-bit instructions over a byte-serial toggle bus.
// Each 8-transfer frame returns PC/acc status bytes, collects four instruction bytes, then executes.
module sticky_cpu_core (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       sync_in,
    input  logic [7:0] data_in,
    output logic       sync_out,
    output logic [7:0] data_out
);

    logic        sync_m, sync_s, sync_prev;
    logic [7:0]  data_m, data_s;
    logic        edge_det;
    logic        vld_p0, vld_p1;
    logic [2:0]  cnt;
    logic [31:0] ir;
    logic [15:0] pc, acc;
    logic [15:0] v_reg [8];
    logic        flag_z, flag_c;

    logic [3:0]  op, rd, rs;
    logic [15:0] imm;
    logic [15:0] op_a, op_b;
    logic [16:0] alu_sum;
    logic        alu_en;
    logic [7:0]  status_byte;

    assign edge_det = sync_s != sync_prev;
    assign op  = ir[31:28];
    assign rd  = ir[27:24];
    assign rs  = ir[23:20];
    assign imm = ir[15:0];

    // Flags have no consumer yet; bits [19:16] of the instruction are reserved.
    logic unused_ok;
    assign unused_ok = &{1'b0, ir[19:16], flag_z, flag_c};

    always_comb begin
        op_a = 16'h0000;
        op_b = 16'h0000;
        if (rd < 4'd8)       op_a = v_reg[rd[2:0]];
        else if (rd == 4'd8) op_a = acc;
        if (rs < 4'd8)       op_b = v_reg[rs[2:0]];
        else if (rs == 4'd8) op_b = acc;

        alu_sum = 17'h00000;
        alu_en  = 1'b0;
        case (op)
            4'h3: begin alu_sum = {1'b0, op_a} + {1'b0, op_b}; alu_en = 1'b1; end
            4'h4: begin alu_sum = {1'b0, op_a} - {1'b0, op_b}; alu_en = 1'b1; end
            4'h5: begin alu_sum = {1'b0, op_a & op_b};         alu_en = 1'b1; end
            4'h6: begin alu_sum = {1'b0, op_a | op_b};         alu_en = 1'b1; end
            4'h7: begin alu_sum = {1'b0, op_a ^ op_b};         alu_en = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        status_byte = 8'h00;
        case (cnt)
            3'd0:    status_byte = pc[7:0];
            3'd1:    status_byte = pc[15:8];
            3'd2:    status_byte = acc[7:0];
            default: status_byte = 8'h00;
        endcase
    end

    // Stage p0: synchronize, detect edge, advance frame and execute
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync_m    <= 1'b0;
            sync_s    <= 1'b0;
            sync_prev <= 1'b0;
            data_m    <= 8'h00;
            data_s    <= 8'h00;
            vld_p0    <= 1'b0;
            cnt       <= 3'd0;
            ir        <= 32'h0000_0000;
            pc        <= 16'h0000;
            acc       <= 16'h0000;
            flag_z    <= 1'b0;
            flag_c    <= 1'b0;
            for (int i = 0; i < 8; i++) v_reg[i] <= 16'h0000;
        end else begin
            sync_m    <= sync_in;
            sync_s    <= sync_m;
            sync_prev <= sync_s;
            data_m    <= data_in;
            data_s    <= data_m;
            vld_p0    <= edge_det;
            if (edge_det) begin
                cnt <= cnt + 3'd1;
                case (cnt)
                    3'd3: ir[7:0]   <= data_s;
                    3'd4: ir[15:8]  <= data_s;
                    3'd5: ir[23:16] <= data_s;
                    3'd6: ir[31:24] <= data_s;
                    3'd7: begin
                        if (op == 4'h1 || op == 4'h2) begin
                            if (rd < 4'd8)       v_reg[rd[2:0]] <= (op == 4'h1) ? imm : op_b;
                            else if (rd == 4'd8) acc            <= (op == 4'h1) ? imm : op_b;
                        end
                        if (alu_en) begin
                            acc    <= alu_sum[15:0];
                            flag_z <= alu_sum[15:0] == 16'h0000;
                            flag_c <= alu_sum[16];
                        end
                        pc <= (op == 4'h9) ? imm : pc + 16'd1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Stage p1: present the byte for the next transfer; stage p2: acknowledge
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            vld_p1   <= 1'b0;
            data_out <= 8'h00;
            sync_out <= 1'b0;
        end else begin
            vld_p1 <= vld_p0;
            if (vld_p0) data_out <= status_byte;
            if (vld_p1) sync_out <= ~sync_out;
        end
    end

endmodule

// File: tb/tb_sticky_cpu_core.sv
// Directed bench for sticky_cpu_core: instruction frames over the toggle bus,
// expected status bytes queued from an instruction-level model.
module tb_sticky_cpu_core;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       sync_in;
    logic [7:0] data_in;
    logic       sync_out;
    logic [7:0] data_out;

    sticky_cpu_core dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .sync_in  (sync_in),
        .data_in  (data_in),
        .sync_out (sync_out),
        .data_out (data_out)
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0]  exp_q [$];
    logic        sync_lvl;
    logic        mdl_ack;
    logic [2:0]  mdl_cnt;
    logic [31:0] mdl_ir;
    logic [15:0] mdl_pc, mdl_acc;
    logic [15:0] mdl_v [8];
    logic [7:0]  last_b;
    logic [7:0]  obs_hi, obs_acc;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_ack = 1'b0;
        mdl_cnt = 3'd0;
        mdl_ir  = 32'h0;
        mdl_pc  = 16'h0;
        mdl_acc = 16'h0;
        for (int i = 0; i < 8; i++) mdl_v[i] = 16'h0;
    endtask

    function automatic logic [15:0] mreg(input logic [3:0] idx);
        if (idx < 4'd8) return mdl_v[idx[2:0]];
        if (idx == 4'd8) return mdl_acc;
        return 16'h0;
    endfunction

    task automatic mwrite(input logic [3:0] idx, input logic [15:0] val);
        if (idx < 4'd8) mdl_v[idx[2:0]] = val;
        else if (idx == 4'd8) mdl_acc = val;
    endtask

    task automatic model_exec(input logic [31:0] ins);
        logic [15:0] a, b, imm;
        a   = mreg(ins[27:24]);
        b   = mreg(ins[23:20]);
        imm = ins[15:0];
        case (ins[31:28])
            4'h1: mwrite(ins[27:24], imm);
            4'h2: mwrite(ins[27:24], b);
            4'h3: mdl_acc = a + b;
            4'h4: mdl_acc = a - b;
            4'h5: mdl_acc = a & b;
            4'h6: mdl_acc = a | b;
            4'h7: mdl_acc = a ^ b;
            default: ;
        endcase
        mdl_pc = (ins[31:28] == 4'h9) ? imm : mdl_pc + 16'd1;
    endtask

    function automatic logic [7:0] model_status();
        case (mdl_cnt)
            3'd0:    return mdl_pc[7:0];
            3'd1:    return mdl_pc[15:8];
            3'd2:    return mdl_acc[7:0];
            default: return 8'h00;
        endcase
    endfunction

    task automatic xfer(input logic [7:0] b);
        logic acked;
        logic [7:0] exp_b;
        case (mdl_cnt)
            3'd3: mdl_ir[7:0]   = b;
            3'd4: mdl_ir[15:8]  = b;
            3'd5: mdl_ir[23:16] = b;
            3'd6: mdl_ir[31:24] = b;
            3'd7: model_exec(mdl_ir);
            default: ;
        endcase
        mdl_cnt = mdl_cnt + 3'd1;
        exp_q.push_back(model_status());
        mdl_ack = ~mdl_ack;

        data_in  = b;
        sync_lvl = ~sync_lvl;
        sync_in  = sync_lvl;
        acked = 1'b0;
        for (int i = 0; i < 24 && !acked; i++) begin
            @(negedge sys_clk);
            if (sync_out === mdl_ack) acked = 1'b1;
        end
        chk("ack", {15'h0, acked}, 16'h1);
        exp_b = exp_q.pop_front();
        chk("data_out", {8'h0, data_out}, {8'h0, exp_b});
        last_b = data_out;
    endtask

    task automatic send_frame(input logic [31:0] ins);
        xfer(8'h00); obs_hi  = last_b;
        xfer(8'h00); obs_acc = last_b;
        xfer(8'h00);
        xfer(ins[7:0]);
        xfer(ins[15:8]);
        xfer(ins[23:16]);
        xfer(ins[31:24]);
        xfer(8'hA5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst  = 1'b1;
        sync_in  = 1'b0;
        sync_lvl = 1'b0;
        data_in  = 8'h00;
        model_reset();
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        chk("rst data_out", {8'h0, data_out}, 16'h0000);
        chk("rst sync_out", {15'h0, sync_out}, 16'h0000);

        // Three status transfers, then finish the MOVI v0,0x0F0F frame
        xfer(8'h00); chk("pc_hi0", {8'h0, last_b}, 16'h0000);
        xfer(8'h00); chk("acc0", {8'h0, last_b}, 16'h0000);
        xfer(8'h00); chk("cnt3 zero", {8'h0, last_b}, 16'h0000);
        chk("three acks", {15'h0, sync_out}, 16'h0001);
        xfer(8'h0F); xfer(8'h0F); xfer(8'h00); xfer(8'h10); xfer(8'h00);
        chk("pc_lo after movi", {8'h0, last_b}, 16'h0001);

        send_frame(32'h3000_0000);                       // ADD v0,v0
        chk("pc_hi after movi", {8'h0, obs_hi}, 16'h0000);
        chk("pc_lo after add", {8'h0, last_b}, 16'h0002);
        send_frame(32'h2280_0000);                       // MOV v2,acc
        chk("acc lo 1E", {8'h0, obs_acc}, 16'h001E);
        send_frame(32'h320F_0000);                       // ADD v2,v0 (reserved bits set)
        send_frame(32'h1100_FFFF);                       // MOVI v1,0xFFFF
        chk("acc lo 2D", {8'h0, obs_acc}, 16'h002D);
        send_frame(32'h1300_0001);                       // MOVI v3,1
        send_frame(32'h3130_0000);                       // ADD v1,v3 wraps to 0
        send_frame(32'h9000_1234);                       // JMP 0x1234
        chk("acc wrap zero", {8'h0, obs_acc}, 16'h0000);
        chk("jmp pc_lo", {8'h0, last_b}, 16'h0034);
        send_frame(32'h4310_0000);                       // SUB v3,v1 = 0x0002
        chk("jmp pc_hi", {8'h0, obs_hi}, 16'h0012);
        send_frame(32'h1900_7777);                       // MOVI r9 dropped
        chk("sub acc", {8'h0, obs_acc}, 16'h0002);
        send_frame(32'h2890_0000);                       // MOV acc,r9 reads 0
        send_frame(32'h7020_0000);                       // XOR v0,v2
        chk("r9 reads zero", {8'h0, obs_acc}, 16'h0000);
        send_frame(32'h6010_0000);                       // OR v0,v1
        send_frame(32'h5230_0000);                       // AND v2,v3
        send_frame(32'hA000_0000);                       // reserved opcode

        // Abort a frame partway with reset
        xfer(8'h00); xfer(8'h00); xfer(8'h00); xfer(8'h55); xfer(8'h00);
        @(negedge sys_clk);
        sys_rst  = 1'b1;
        sync_lvl = 1'b0;
        sync_in  = 1'b0;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        model_reset();
        @(negedge sys_clk);
        chk("midrst data_out", {8'h0, data_out}, 16'h0000);
        chk("midrst sync_out", {15'h0, sync_out}, 16'h0000);

        send_frame(32'h1800_0055);                       // MOVI acc,0x55
        chk("post-rst pc_hi", {8'h0, obs_hi}, 16'h0000);
        chk("post-rst pc_lo", {8'h0, last_b}, 16'h0001);
        send_frame(32'h0000_0000);
        chk("post-rst acc", {8'h0, obs_acc}, 16'h0055);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
